// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline front-end sequencer and the CPU datapath.
// The slave modport is the sequencer. The master modport is the datapath/hazard side.
interface pipeline_sequencer_if;
  logic        halt;
  logic        go;
  logic        jmp_ok;
  logic        load_use;
  logic        imem_ack;
  logic        imem_req;
  logic        pc_enable;
  logic        ifid_enable;
  logic        ifid_flush;
  logic        idex_enable;
  logic        idex_flush;
  logic        exmem_flush;
  logic        halted;
  logic        fault;
  logic [31:0] cycle_count;
  logic [31:0] stall_count;
  logic [31:0] redirect_count;

  modport master (
    output halt, go, jmp_ok, load_use, imem_ack,
    input  imem_req, pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
           exmem_flush, halted, fault, cycle_count, stall_count, redirect_count
  );

  modport slave (
    input  halt, go, jmp_ok, load_use, imem_ack,
    output imem_req, pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
           exmem_flush, halted, fault, cycle_count, stall_count, redirect_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// MIPS front-end sequencer: PC/IF-ID/ID-EX hold/advance/flush, halt/resume, fetch timeout.
// Define PIPELINE_SEQ_STATS_EN to build the cycle/stall/redirect performance counters.
module pipeline_sequencer #(
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT, S_FAULT} state_t;

  localparam logic [7:0] TIMEOUT = IMEM_TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [7:0] wait_cnt, wait_d;
  logic       go_q;

  logic imem_req, pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_fl, halted, fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      wait_cnt <= '0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      go_q     <= bus.go;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_cnt;
    imem_req = 1'b0;
    pc_en    = 1'b0;
    ifid_en  = 1'b0;
    ifid_fl  = 1'b0;
    idex_en  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    if (rst) begin
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      exmem_fl = 1'b1;
      state_d  = S_RUN;
      wait_d   = '0;
    end else begin
      unique case (state_q)
        S_RUN, S_WAIT: begin
          imem_req = 1'b1;
          if (bus.halt) begin
            imem_req = 1'b0;
            ifid_fl  = 1'b1;
            idex_fl  = 1'b1;
            wait_d   = '0;
            state_d  = S_HALT;
          end else if (!bus.imem_ack) begin
            // Freeze the front end; EX keeps its redirect until the fetch lands.
            exmem_fl = 1'b1;
            wait_d   = wait_cnt + 8'd1;
            state_d  = (wait_d == TIMEOUT) ? S_FAULT : S_WAIT;
          end else if (bus.jmp_ok) begin
            // Redirect wins over load_use: the stalled instruction is wrong-path.
            pc_en   = 1'b1;
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
            wait_d  = '0;
            state_d = S_RUN;
          end else if (bus.load_use) begin
            idex_fl = 1'b1;
            idex_en = 1'b1;
            wait_d  = '0;
            state_d = S_RUN;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
            wait_d  = '0;
            state_d = S_RUN;
          end
        end
        S_HALT: begin
          halted = 1'b1;
          if (bus.go && !go_q) state_d = S_RUN;
        end
        S_FAULT: fault = 1'b1;
        default: state_d = S_RUN;
      endcase
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.pc_enable   = pc_en;
  assign bus.ifid_enable = ifid_en;
  assign bus.ifid_flush  = ifid_fl;
  assign bus.idex_enable = idex_en;
  assign bus.idex_flush  = idex_fl;
  assign bus.exmem_flush = exmem_fl;
  assign bus.halted      = halted;
  assign bus.fault       = fault;

`ifdef PIPELINE_SEQ_STATS_EN
  logic        active, stall_inc, redir_inc;
  logic [31:0] cycle_q, stall_q, redir_q;

  assign active    = (state_q == S_RUN) || (state_q == S_WAIT);
  assign stall_inc = active && !bus.halt &&
                     (!bus.imem_ack || (!bus.jmp_ok && bus.load_use));
  assign redir_inc = active && !bus.halt && bus.imem_ack && bus.jmp_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (active)    cycle_q <= cycle_q + 32'd1;
      if (stall_inc) stall_q <= stall_q + 32'd1;
      if (redir_inc) redir_q <= redir_q + 32'd1;
    end
  end

  assign bus.cycle_count    = cycle_q;
  assign bus.stall_count    = stall_q;
  assign bus.redirect_count = redir_q;
`else
  assign bus.cycle_count    = '0;
  assign bus.stall_count    = '0;
  assign bus.redirect_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer (IMEM_TIMEOUT=4): vector table plus multi-cycle sequences.
module tb_pipeline_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_sequencer_if bus();
  pipeline_sequencer #(.IMEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef PIPELINE_SEQ_STATS_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  // {imem_req, pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush, exmem_flush}
  localparam logic [6:0] O_RST  = 7'b0001011;
  localparam logic [6:0] O_FLOW = 7'b1110100;
  localparam logic [6:0] O_LU   = 7'b1000110;
  localparam logic [6:0] O_JMP  = 7'b1101010;
  localparam logic [6:0] O_WAIT = 7'b1000001;
  localparam logic [6:0] O_HLT  = 7'b0001010;
  localparam logic [6:0] O_IDLE = 7'b0000000;

  typedef struct {
    string      name;
    logic [4:0] in;   // {halt, go, jmp_ok, load_use, imem_ack}
    logic [6:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[8];

  function automatic logic [6:0] outs();
    return {bus.imem_req, bus.pc_enable, bus.ifid_enable, bus.ifid_flush,
            bus.idex_enable, bus.idex_flush, bus.exmem_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] in);
    {bus.halt, bus.go, bus.jmp_ok, bus.load_use, bus.imem_ack} = in;
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"flow",       5'b00001, O_FLOW};
    tbl[1] = '{"load_use",   5'b00011, O_LU};
    tbl[2] = '{"jmp",        5'b00101, O_JMP};
    tbl[3] = '{"jmp_lu",     5'b00111, O_JMP};
    tbl[4] = '{"wait_jmp",   5'b00110, O_WAIT};
    tbl[5] = '{"wait_plain", 5'b00000, O_WAIT};
    tbl[6] = '{"halt_all",   5'b11111, O_HLT};
    tbl[7] = '{"halt_wait",  5'b10000, O_HLT};

    // Reset state
    drive(5'b00001);
    chk("rst_outs", 32'(outs()), 32'(O_RST));
    tick();
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_cycle", bus.cycle_count, 0);
    chk("rst_stall", bus.stall_count, 0);
    rst = 1'b0;

    // Steady flow
    for (int i = 0; i < 10; i++) begin
      drive(5'b00001);
      chk("flow_outs", 32'(outs()), 32'(O_FLOW));
      tick();
    end
    chk("flow_cycle", bus.cycle_count, 32'(10 * S));
    chk("flow_stall", bus.stall_count, 0);

    // Vector table, each from a fresh RUN state
    for (int i = 0; i < 8; i++) begin
      pulse_reset();
      drive(tbl[i].in);
      chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
    end

    // Redirect and load_use together
    pulse_reset();
    drive(5'b00111);
    tick();
    chk("jlu_redir", bus.redirect_count, 32'(S));
    chk("jlu_stall", bus.stall_count, 0);

    // Three frozen cycles with jmp_ok held, then redirect on the ack
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'b00100);
      chk("frz_outs", 32'(outs()), 32'(O_WAIT));
      tick();
    end
    drive(5'b00101);
    chk("frz_redir_outs", 32'(outs()), 32'(O_JMP));
    tick();
    chk("frz_stall", bus.stall_count, 32'(3 * S));
    chk("frz_redir", bus.redirect_count, 32'(S));
    chk("frz_cycle", bus.cycle_count, 32'(4 * S));
    drive(5'b00001);
    chk("frz_after", 32'(outs()), 32'(O_FLOW));

    // Halt with go already high, then go edge resumes
    pulse_reset();
    drive(5'b11001);
    chk("hlt_outs", 32'(outs()), 32'(O_HLT));
    tick();
    drive(5'b01001);
    chk("hlt_halted", 32'(bus.halted), 1);
    chk("hlt_idle", 32'(outs()), 32'(O_IDLE));
    tick();
    tick();
    chk("hlt_go_held", 32'(bus.halted), 1);
    drive(5'b00001);
    tick();
    chk("hlt_go_low", 32'(bus.halted), 1);
    drive(5'b01001);
    chk("hlt_go_rise", 32'(bus.halted), 1);
    tick();
    chk("resume_halted", 32'(bus.halted), 0);
    chk("resume_outs", 32'(outs()), 32'(O_FLOW));

    // Timeout: four un-acked cycles, fault from cycle 5
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'b00000);
      chk("to_nofault", 32'(bus.fault), 0);
      chk("to_outs", 32'(outs()), 32'(O_WAIT));
      tick();
    end
    drive(5'b00000);
    chk("to_fault", 32'(bus.fault), 1);
    chk("to_fault_outs", 32'(outs()), 32'(O_IDLE));
    drive(5'b00001);
    tick();
    tick();
    chk("to_fault_sticky", 32'(bus.fault), 1);
    rst = 1'b1;
    #2;
    chk("to_rst_outs", 32'(outs()), 32'(O_RST));
    chk("to_rst_fault", 32'(bus.fault), 0);
    tick();
    rst = 1'b0;
    drive(5'b00001);
    chk("to_clear_fault", 32'(bus.fault), 0);
    chk("to_clear_outs", 32'(outs()), 32'(O_FLOW));

    // Ack on the 4th cycle avoids the fault
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'b00000);
      tick();
    end
    drive(5'b00001);
    chk("ack4_outs", 32'(outs()), 32'(O_FLOW));
    tick();
    chk("ack4_nofault", 32'(bus.fault), 0);

    // Reset during WAIT forces outputs and discards the pending count
    for (int i = 0; i < 3; i++) begin
      drive(5'b00000);
      tick();
    end
    rst = 1'b1;
    #2;
    chk("wrst_outs", 32'(outs()), 32'(O_RST));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(5'b00000);
      chk("wrst_wait_outs", 32'(outs()), 32'(O_WAIT));
      tick();
    end
    drive(5'b00001);
    chk("wrst_nofault", 32'(bus.fault), 0);
    chk("wrst_flow", 32'(outs()), 32'(O_FLOW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
